// File: rtl/jalr_target_resolver_if.sv
// Fetch-side bus of the JALR target resolver: request handshake in, resolved target handshake out.
// Every field is a flat per-channel vector, so channel c's rs1 is at [5c+:5].
interface jalr_target_resolver_if #(
   parameter int N_CH = 4,
   parameter int XLEN = 32
);
   logic [N_CH-1:0]      req_valid;
   logic [5*N_CH-1:0]    req_rs1;
   logic [XLEN*N_CH-1:0] req_imm;
   logic [N_CH-1:0]      req_ready;
   logic [N_CH-1:0]      tgt_valid;
   logic [XLEN*N_CH-1:0] tgt_addr;
   logic [N_CH-1:0]      tgt_ack;
   logic [N_CH-1:0]      hang;

   modport master (
      output req_valid, req_rs1, req_imm, tgt_ack,
      input  req_ready, tgt_valid, tgt_addr, hang
   );

   modport slave (
      input  req_valid, req_rs1, req_imm, tgt_ack,
      output req_ready, tgt_valid, tgt_addr, hang
   );
endinterface

// File: rtl/jalr_target_resolver.sv
// Per-channel JALR target resolver: holds each request while rs1 has an in-flight producer,
// forwards rs1 from MEM when possible and registers (rs1+imm)&~1 behind a valid/ack handshake.
module jalr_target_resolver #(
   parameter int N_CH      = 4,
   parameter int N_IND     = 2,
   parameter int XLEN      = 32,
   parameter int STALL_MAX = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   jalr_target_resolver_if.slave fetch,
   output logic [5*N_CH-1:0]    rf_raddr,
   input  logic [XLEN*N_CH-1:0] rf_rdata,
   input  logic [5*N_IND-1:0]   ind_rd,
   input  logic [N_IND-1:0]     ind_wen,
   input  logic [4:0]           exe_rd,
   input  logic                 exe_wen,
   input  logic [4:0]           mem_rd,
   input  logic                 mem_wen,
   input  logic                 mem_load,
   input  logic [XLEN-1:0]      mem_data
);

   localparam int CW    = $clog2(STALL_MAX + 1);
   localparam int GROUP = N_CH / N_IND;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t               state [N_CH];
   logic [4:0]           rs1_q [N_CH];
   logic [XLEN-1:0]      imm_q [N_CH];
   logic [CW-1:0]        cnt_q [N_CH];
   logic [N_CH-1:0]      valid_q;
   logic [N_CH-1:0]      hang_q;
   logic [XLEN*N_CH-1:0] addr_q;
   logic [N_CH-1:0]      blocked;
   logic [N_CH-1:0]      ready;
   logic [XLEN*N_CH-1:0] tgt_next;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      localparam int SLOT = c / GROUP;
      logic            nz;
      logic            ind_hit;
      logic            exe_hit;
      logic            mem_hit;
      logic [XLEN-1:0] operand;
      logic [XLEN-1:0] sum;

      // x0 never has a producer, so every hazard term is masked and the operand is zero
      assign nz      = rs1_q[c] != 5'd0;
      assign ind_hit = nz && ind_wen[SLOT] && (ind_rd[5*SLOT +: 5] == rs1_q[c]);
      assign exe_hit = nz && exe_wen && (exe_rd == rs1_q[c]);
      assign mem_hit = nz && mem_wen && (mem_rd == rs1_q[c]);

      assign blocked[c] = ind_hit || exe_hit || (mem_hit && mem_load);
      assign operand    = !nz ? '0 : (mem_hit ? mem_data : rf_rdata[XLEN*c +: XLEN]);
      assign sum        = operand + imm_q[c];

      assign tgt_next[XLEN*c +: XLEN] = sum & {{(XLEN-1){1'b1}}, 1'b0};
      assign rf_raddr[5*c +: 5]       = rs1_q[c];
      assign ready[c]                 = state[c] == IDLE;
   end

   assign fetch.req_ready = ready;
   assign fetch.tgt_valid = valid_q;
   assign fetch.tgt_addr  = addr_q;
   assign fetch.hang      = hang_q;

   // Reset beats flush, flush beats every per-channel transition
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            state[c] <= IDLE;
            rs1_q[c] <= '0;
            imm_q[c] <= '0;
            cnt_q[c] <= '0;
         end
         valid_q <= '0;
         hang_q  <= '0;
         addr_q  <= '0;
      end else if (flush) begin
         for (int c = 0; c < N_CH; c++) begin
            state[c] <= IDLE;
            cnt_q[c] <= '0;
         end
         valid_q <= '0;
         hang_q  <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            case (state[c])
               IDLE: begin
                  if (fetch.req_valid[c]) begin
                     rs1_q[c] <= fetch.req_rs1[5*c +: 5];
                     imm_q[c] <= fetch.req_imm[XLEN*c +: XLEN];
                     cnt_q[c] <= '0;
                     state[c] <= WAIT;
                  end
               end
               WAIT: begin
                  if (blocked[c]) begin
                     if (cnt_q[c] != CW'(STALL_MAX))
                        cnt_q[c] <= cnt_q[c] + CW'(1);
                     hang_q[c] <= cnt_q[c] >= CW'(STALL_MAX - 1);
                  end else begin
                     addr_q[XLEN*c +: XLEN] <= tgt_next[XLEN*c +: XLEN];
                     valid_q[c]             <= 1'b1;
                     hang_q[c]              <= 1'b0;
                     state[c]               <= DONE;
                  end
               end
               DONE: begin
                  if (fetch.tgt_ack[c]) begin
                     valid_q[c] <= 1'b0;
                     state[c]   <= IDLE;
                  end
               end
               default: state[c] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jalr_target_resolver.sv
// Scoreboard bench for jalr_target_resolver: directed hazard/latency cases plus randomized rounds
// checked against a plain-arithmetic model of the target rule.
module tb_jalr_target_resolver;

   localparam int N_CH      = 4;
   localparam int N_IND     = 2;
   localparam int XLEN      = 32;
   localparam int STALL_MAX = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 flush;
   logic [5*N_CH-1:0]    rf_raddr;
   logic [XLEN*N_CH-1:0] rf_rdata;
   logic [5*N_IND-1:0]   ind_rd;
   logic [N_IND-1:0]     ind_wen;
   logic [4:0]           exe_rd;
   logic                 exe_wen;
   logic [4:0]           mem_rd;
   logic                 mem_wen;
   logic                 mem_load;
   logic [XLEN-1:0]      mem_data;

   logic [31:0] regs [32];
   logic [31:0] exp_q [N_CH][$];
   int          total = 0;
   int          bad   = 0;

   jalr_target_resolver_if #(.N_CH(N_CH), .XLEN(XLEN)) bus ();

   jalr_target_resolver #(
      .N_CH(N_CH), .N_IND(N_IND), .XLEN(XLEN), .STALL_MAX(STALL_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .fetch(bus),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .ind_rd(ind_rd), .ind_wen(ind_wen),
      .exe_rd(exe_rd), .exe_wen(exe_wen),
      .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_load(mem_load), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   // Register file model answering the DUT's combinational read ports
   always_comb begin
      rf_rdata = '0;
      for (int c = 0; c < N_CH; c++)
         rf_rdata[XLEN*c +: XLEN] = regs[rf_raddr[5*c +: 5]];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: a target is consumed when valid and ack meet at an edge that is not reset or flush
   always @(negedge clk) begin
      if (rst_n && !flush) begin
         for (int c = 0; c < N_CH; c++) begin
            if (bus.tgt_valid[c] && bus.tgt_ack[c]) begin
               if (exp_q[c].size() == 0)
                  checkOutput($sformatf("unexpected_target_ch%0d", c), bus.tgt_addr[XLEN*c +: XLEN], 32'hFFFF_FFFF);
               else
                  checkOutput($sformatf("target_ch%0d", c), bus.tgt_addr[XLEN*c +: XLEN], exp_q[c].pop_front());
            end
         end
      end
   end

   function automatic int pending();
      int n = 0;
      for (int c = 0; c < N_CH; c++) n += exp_q[c].size();
      return n;
   endfunction

   function automatic logic [31:0] modelTarget(input logic [4:0] rs1, input logic [31:0] imm);
      logic [31:0] op;
      if (rs1 == 5'd0)                    op = 32'd0;
      else if (mem_wen && mem_rd == rs1)  op = mem_data;
      else                                op = regs[rs1];
      return (op + imm) & 32'hFFFF_FFFE;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int c, input logic [4:0] rs1, input logic [31:0] imm,
                                input logic [31:0] expected, input bit push);
      bus.req_valid[c]           = 1'b1;
      bus.req_rs1[5*c +: 5]      = rs1;
      bus.req_imm[XLEN*c +: XLEN] = imm;
      if (push) exp_q[c].push_back(expected);
   endtask

   task automatic clearQueues();
      for (int c = 0; c < N_CH; c++) exp_q[c].delete();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      ind_rd = '0; ind_wen = '0; exe_rd = '0; exe_wen = 1'b0;
      mem_rd = '0; mem_wen = 1'b0; mem_load = 1'b0; mem_data = '0;
      bus.req_valid = '0; bus.req_rs1 = '0; bus.req_imm = '0; bus.tgt_ack = '0;
      for (int i = 0; i < 32; i++) regs[i] = 32'h100 * i;

      tick(); tick();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_ready", bus.req_ready, 4'hF);
      checkOutput("reset_valid", bus.tgt_valid, 4'h0);
      checkOutput("reset_hang", bus.hang, 4'h0);
      checkOutput("reset_addr_ch0", bus.tgt_addr[31:0], 32'h0);

      // Ch0 no hazard: valid one edge after capture, held stable until ack
      regs[5] = 32'h1000;
      tick();
      applyStimulus(0, 5'd5, 32'h13, 32'h1012, 1'b1);
      tick(); bus.req_valid = '0;
      @(negedge clk);
      checkOutput("t1_valid_e0", bus.tgt_valid[0], 1'b0);
      checkOutput("t1_ready_busy", bus.req_ready[0], 1'b0);
      tick(); @(negedge clk);
      checkOutput("t1_valid_e1", bus.tgt_valid[0], 1'b1);
      checkOutput("t1_addr_e1", bus.tgt_addr[31:0], 32'h1012);
      for (int i = 0; i < 3; i++) begin
         tick(); @(negedge clk);
         checkOutput("t1_hold_valid", bus.tgt_valid[0], 1'b1);
         checkOutput("t1_hold_addr", bus.tgt_addr[31:0], 32'h1012);
      end
      tick(); bus.tgt_ack[0] = 1'b1;
      tick(); bus.tgt_ack = '0;
      @(negedge clk);
      checkOutput("t1_ready_after_ack", bus.req_ready[0], 1'b1);
      checkOutput("t1_valid_after_ack", bus.tgt_valid[0], 1'b0);

      // Ch2 blocked by its own InDecode slot for three edges
      regs[7] = 32'h3000;
      tick();
      applyStimulus(2, 5'd7, 32'h4, 32'h3004, 1'b1);
      ind_rd = {5'd7, 5'd0}; ind_wen = 2'b10;
      tick(); bus.req_valid = '0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 3) ind_wen = '0;
         @(negedge clk);
         checkOutput($sformatf("t2_slot1_valid_e%0d", i), bus.tgt_valid[2], (i == 4));
      end
      bus.tgt_ack[2] = 1'b1; tick(); bus.tgt_ack = '0;

      // Same hazard in the other slot must not hold ch2
      applyStimulus(2, 5'd7, 32'h4, 32'h3004, 1'b1);
      ind_rd = {5'd0, 5'd7}; ind_wen = 2'b01;
      tick(); bus.req_valid = '0;
      tick(); @(negedge clk);
      checkOutput("t2_slot0_valid_e1", bus.tgt_valid[2], 1'b1);
      tick(); bus.tgt_ack[2] = 1'b1; tick(); bus.tgt_ack = '0; ind_wen = '0;

      // Ch1 forwarding from MEM beats the register file
      regs[9] = 32'hDEAD;
      mem_rd = 5'd9; mem_wen = 1'b1; mem_data = 32'h2001; mem_load = 1'b0;
      applyStimulus(1, 5'd9, 32'hFFFF_FFFF, 32'h2000, 1'b1);
      tick(); bus.req_valid = '0;
      tick(); @(negedge clk);
      checkOutput("t3_fwd_valid_e1", bus.tgt_valid[1], 1'b1);
      checkOutput("t3_fwd_addr", bus.tgt_addr[63:32], 32'h2000);
      tick(); bus.tgt_ack[1] = 1'b1; tick(); bus.tgt_ack = '0;

      // Load in MEM stalls two edges, then forwards
      mem_load = 1'b1;
      applyStimulus(1, 5'd9, 32'hFFFF_FFFF, 32'h2000, 1'b1);
      tick(); bus.req_valid = '0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i == 2) mem_load = 1'b0;
         @(negedge clk);
         checkOutput($sformatf("t3_load_valid_e%0d", i), bus.tgt_valid[1], (i == 3));
      end
      tick(); bus.tgt_ack[1] = 1'b1; tick(); bus.tgt_ack = '0; mem_wen = 1'b0;

      // x0: EXE/MEM hits on register 0 neither stall nor forward
      regs[0] = 32'h55; exe_rd = 5'd0; exe_wen = 1'b1;
      mem_rd = 5'd0; mem_wen = 1'b1; mem_data = 32'h777;
      applyStimulus(3, 5'd0, 32'h401, 32'h400, 1'b1);
      tick(); bus.req_valid = '0;
      tick(); @(negedge clk);
      checkOutput("t4_x0_valid_e1", bus.tgt_valid[3], 1'b1);
      checkOutput("t4_x0_addr", bus.tgt_addr[127:96], 32'h400);
      tick(); bus.tgt_ack[3] = 1'b1; tick(); bus.tgt_ack = '0;
      exe_wen = 1'b0; mem_wen = 1'b0; regs[0] = 32'h0;

      // Permanent EXE hazard: hang after STALL_MAX blocked edges, then flush clears everything
      exe_rd = 5'd3; exe_wen = 1'b1;
      applyStimulus(0, 5'd3, 32'h0, 32'h0, 1'b0);
      tick(); bus.req_valid = '0;
      for (int i = 1; i <= 6; i++) begin
         tick(); @(negedge clk);
         if (i == STALL_MAX - 1) checkOutput("t5_hang_before", bus.hang[0], 1'b0);
         if (i == STALL_MAX)     checkOutput("t5_hang_at_max", bus.hang[0], 1'b1);
         if (i == 6)             checkOutput("t5_hang_saturated", bus.hang[0], 1'b1);
      end
      checkOutput("t5_no_target_while_blocked", bus.tgt_valid[0], 1'b0);
      tick();
      flush = 1'b1;
      applyStimulus(3, 5'd1, 32'h8, 32'h0, 1'b0);
      tick(); flush = 1'b0; bus.req_valid = '0; exe_wen = 1'b0;
      @(negedge clk);
      checkOutput("t5_flush_hang", bus.hang, 4'h0);
      checkOutput("t5_flush_valid", bus.tgt_valid, 4'h0);
      checkOutput("t5_flush_ready", bus.req_ready, 4'hF);
      tick(); tick(); @(negedge clk);
      checkOutput("t5_flush_no_late_target", bus.tgt_valid, 4'h0);

      // All channels resolve together with wrap-around, then reset in DONE discards them
      for (int c = 0; c < N_CH; c++) begin
         regs[10 + c] = 32'hFFFF_FFFF;
         applyStimulus(c, 5'(10 + c), 32'h3, 32'h2, 1'b1);
      end
      tick(); bus.req_valid = '0;
      tick(); @(negedge clk);
      checkOutput("t6_all_valid", bus.tgt_valid, 4'hF);
      for (int c = 0; c < N_CH; c++)
         checkOutput($sformatf("t6_wrap_addr_ch%0d", c), bus.tgt_addr[XLEN*c +: XLEN], 32'h2);
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1; clearQueues();
      @(negedge clk);
      checkOutput("t6_reset_valid", bus.tgt_valid, 4'h0);
      checkOutput("t6_reset_ready", bus.req_ready, 4'hF);
      checkOutput("t6_reset_addr_ch2", bus.tgt_addr[95:64], 32'h0);

      // Randomized rounds with transient hazards and random acks
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      for (int r = 0; r < 40; r++) begin
         int guard;
         int hcyc;
         logic [N_CH-1:0] mask;
         tick();
         mem_wen  = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
         mem_load = 1'($urandom);
         exe_wen  = 1'b1; exe_rd = 5'($urandom_range(0, 7));
         ind_wen  = 2'($urandom); ind_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         hcyc     = $urandom_range(0, 3);
         mask     = 4'($urandom);
         for (int c = 0; c < N_CH; c++) begin
            if (mask[c]) begin
               logic [4:0]  rs1;
               logic [31:0] imm;
               rs1 = 5'($urandom_range(0, 7));
               imm = $urandom;
               applyStimulus(c, rs1, imm, modelTarget(rs1, imm), 1'b1);
            end
         end
         tick(); bus.req_valid = '0;
         for (int k = 0; k < hcyc; k++) tick();
         exe_wen = 1'b0; ind_wen = '0; mem_load = 1'b0;
         guard = 0;
         while ((pending() != 0 || bus.req_ready != 4'hF) && guard < 60) begin
            bus.tgt_ack = 4'($urandom);
            tick();
            guard++;
         end
         bus.tgt_ack = '0;
         checkOutput($sformatf("rand_round%0d_done", r), (guard < 60), 1'b1);
         if (guard >= 60) clearQueues();
      end

      tick(); tick();
      checkOutput("queues_drained", pending(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jalr_target_resolver.md
Name: jalr_target_resolver

Overview:
- Parametrised, stateful successor to the combinational JALR forwarding check.
- Accepts up to N_CH independent JALR requests from the fetch stage and holds each one while rs1 has an in-flight producer.
- Forwards rs1 from MEM when legal and computes the jump target (rs1+imm)&~1 into a registered, handshaked output per channel.
- Sits between InFetch, the register file read ports and the decode/execute/memory hazard buses.

Parameters:
- N_CH, 4, number of fetch-side JALR request channels.
- N_IND, 2, number of InDecode slots; channel c checks slot c/(N_CH/N_IND); N_CH must be a multiple of N_IND.
- XLEN, 32, data/address width.
- STALL_MAX, 255, WAIT-cycle count at which hang is raised; counter width = clog2(STALL_MAX+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush; aborts all channels.
- req_valid  in  N_CH  per-channel JALR request.
- req_rs1  in  5*N_CH  rs1 index, channel c at [5c+:5].
- req_imm  in  XLEN*N_CH  sign-extended I-immediate.
- req_ready  out  N_CH  channel can accept (state IDLE).
- rf_raddr  out  5*N_CH  captured rs1 driven to register file.
- rf_rdata  in  XLEN*N_CH  register file data for rf_raddr (combinational read).
- ind_rd  in  5*N_IND  InDecode destination registers.
- ind_wen  in  N_IND  InDecode RegWrite.
- exe_rd  in  5  EXE destination register.
- exe_wen  in  1  EXE RegWrite.
- mem_rd  in  5  MEM destination register.
- mem_wen  in  1  MEM RegWrite.
- mem_load  in  1  MEM MemtoReg (data not yet available).
- mem_data  in  XLEN  MEM-stage ALU result.
- tgt_valid  out  N_CH  target valid.
- tgt_addr  out  XLEN*N_CH  resolved target, bit0 = 0.
- tgt_ack  in  N_CH  fetch consumed target.
- hang  out  N_CH  channel has stalled STALL_MAX cycles.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all channels go to IDLE.
  - tgt_valid=0, tgt_addr=0, hang=0, stall counters=0, captured rs1/imm=0.
  - req_ready=all ones after the reset edge.
- Per-channel FSM IDLE/WAIT/DONE:
  - IDLE: req_ready=1. If req_valid is high at an edge, capture rs1 and imm and go to WAIT; clear the stall counter.
  - WAIT, hazard terms on the captured rs1:
    - ind_hit = ind_wen[slot] & ind_rd[slot]==rs1.
    - exe_hit = exe_wen & exe_rd==rs1.
    - mem_hit = mem_wen & mem_rd==rs1.
    - mem_stall = mem_hit & mem_load.
  - rs1==0: all hit terms are forced 0 and operand=0. This x0 rule is new behaviour.
  - blocked = ind_hit | exe_hit | mem_stall.
  - WAIT, blocked: stay in WAIT; stall counter increments and saturates at STALL_MAX; hang=1 while counter==STALL_MAX.
  - WAIT, not blocked:
    - operand = mem_hit ? mem_data : rf_rdata[c].
    - tgt_addr <= (operand+imm) mod 2^XLEN with bit0 cleared.
    - tgt_valid <= 1; go to DONE; hang <= 0.
  - DONE: tgt_valid and tgt_addr stay stable until tgt_ack. On ack go to IDLE and drop tgt_valid the same edge. req_ready=0 in DONE.
- Latency: request accepted at edge E0. With no hazard, tgt_valid is high after E1. Each blocked cycle adds one cycle.
- req_valid is ignored outside IDLE.
- Priority at an edge: rst_n low > flush > ack/capture/resolve.
- flush:
  - every channel goes to IDLE; tgt_valid=0, hang=0, counters=0.
  - any req_valid in the same cycle is dropped.
- Channels are fully independent; all may resolve in the same cycle.
- tgt_ack while not in DONE is ignored.
- MEM forwarding takes priority over rf_rdata; the EXE/IND checks block even if a MEM hit also exists.
- Reset mid-WAIT or mid-DONE discards the request; no target is emitted.

Test Plan:
- Ch0 req rs1=5, rf_rdata=0x1000, imm=0x13, no hazards → tgt_valid after E1, tgt_addr=0x1012; hold 3 cycles without ack, value stable; ack → IDLE, req_ready=1.
- Ch2 req rs1=7, ind_rd[1]=7, ind_wen[1]=1 for 3 cycles, then clear → tgt_valid 4 cycles after the capture edge. Same stimulus on ind_rd[0] does not stall ch2.
- Ch1 req rs1=9, mem_rd=9, mem_wen=1, mem_data=0x2001, mem_load=0, rf_rdata=0xDEAD, imm=-1 → tgt_addr=0x2000. Repeat with mem_load=1 for 2 cycles → stalls 2 cycles, then resolves.
- rs1=0, exe_rd=0, exe_wen=1, imm=0x401 → no stall, tgt_addr=0x400.
- Hazard held permanently with STALL_MAX=4 → hang=1 on the 4th WAIT cycle, counter saturated. Then flush → all channels IDLE, hang=0, tgt_valid=0.
- All 4 channels request simultaneously, operand 0xFFFFFFFF, imm=3 → all resolve in parallel with wrap-around tgt_addr=0x2. rst_n=0 while in DONE → tgt_valid=0 next cycle.
